// File: rtl/sand_brush_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : sand_brush_ctrl
// Brief   : Stamps a filled disc of one cell type into the falling-sand cell
//           memory through a request/grant write port.
// Revision: 1.0 - initial release
// ============================================================================
module sand_brush_ctrl #(
    parameter int GRID_W = 160,
    parameter int GRID_H = 120,
    parameter int ADDR_W = 15
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [7:0]        radius,
    input  logic [1:0]        cell_type,
    output logic              busy,
    output logic              done,
    output logic              mem_req,
    input  logic              mem_grant,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [1:0]        mem_wdata,
    output logic              mem_we
);

    localparam logic [31:0] c_GRID_W = 32'(GRID_W);
    localparam logic [31:0] c_GRID_H = 32'(GRID_H);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_SCAN = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;

    logic [7:0]         r_x;
    logic [7:0]         r_y;
    logic [7:0]         r_radius;
    logic [1:0]         r_type;
    logic signed [8:0]  r_dx;
    logic signed [8:0]  r_dy;
    logic signed [8:0]  w_dx_next;
    logic signed [8:0]  w_dy_next;
    logic               w_load;

    logic signed [8:0]  w_r9;
    logic signed [8:0]  w_neg_r;
    logic signed [8:0]  w_neg_in;
    logic [9:0]         w_px;
    logic [9:0]         w_py;
    logic               w_px_ok;
    logic               w_py_ok;
    logic [8:0]         w_adx;
    logic [8:0]         w_ady;
    logic [16:0]        w_dx_sq;
    logic [16:0]        w_dy_sq;
    logic [17:0]        w_dist;
    logic [15:0]        w_r_sq;
    logic               w_in_disc;
    logic               w_valid;
    logic               w_req;
    logic [ADDR_W-1:0]  w_addr;

    // ------------------------------------------------------------------
    // Point geometry for the current (dx, dy) offset
    // ------------------------------------------------------------------
    assign w_r9     = $signed({1'b0, r_radius});
    assign w_neg_r  = -w_r9;
    assign w_neg_in = -$signed({1'b0, radius});

    // Two's-complement wrap in 10 bits gives the signed sum directly.
    assign w_px = {2'b00, r_x} + {r_dx[8], r_dx};
    assign w_py = {2'b00, r_y} + {r_dy[8], r_dy};

    assign w_px_ok = !w_px[9] && (32'(w_px[8:0]) < c_GRID_W);
    assign w_py_ok = !w_py[9] && (32'(w_py[8:0]) < c_GRID_H);

    assign w_adx   = r_dx[8] ? (~r_dx + 9'd1) : r_dx;
    assign w_ady   = r_dy[8] ? (~r_dy + 9'd1) : r_dy;
    assign w_dx_sq = 17'(w_adx) * 17'(w_adx);
    assign w_dy_sq = 17'(w_ady) * 17'(w_ady);
    assign w_dist  = 18'(w_dx_sq) + 18'(w_dy_sq);
    assign w_r_sq  = 16'(r_radius) * 16'(r_radius);

    assign w_in_disc = (w_dist <= 18'(w_r_sq));
    assign w_valid   = w_px_ok && w_py_ok && w_in_disc;

    assign w_addr = ADDR_W'(w_py[8:0]) * ADDR_W'(GRID_W) + ADDR_W'(w_px[8:0]);

    // ------------------------------------------------------------------
    // State register and latched stamp parameters
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_x      <= 8'd0;
            r_y      <= 8'd0;
            r_radius <= 8'd0;
            r_type   <= 2'd0;
            r_dx     <= 9'sd0;
            r_dy     <= 9'sd0;
        end else begin
            r_state <= w_state_next;
            r_dx    <= w_dx_next;
            r_dy    <= w_dy_next;
            if (w_load) begin
                r_x      <= x;
                r_y      <= y;
                r_radius <= radius;
                r_type   <= cell_type;
            end
        end
    end

    // ------------------------------------------------------------------
    // Next state, scan stepping and outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_next = r_state;
        w_dx_next    = r_dx;
        w_dy_next    = r_dy;
        w_load       = 1'b0;
        w_req        = 1'b0;
        busy         = 1'b0;
        done         = 1'b0;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_load       = 1'b1;
                    w_dx_next    = w_neg_in;
                    w_dy_next    = w_neg_in;
                    w_state_next = S_SCAN;
                end
            end
            S_SCAN: begin
                busy  = 1'b1;
                w_req = w_valid;
                // Grant only affects stepping, never the request itself.
                if (!w_valid || mem_grant) begin
                    if (r_dx == w_r9) begin
                        if (r_dy == w_r9) begin
                            w_state_next = S_DONE;
                        end else begin
                            w_dx_next = w_neg_r;
                            w_dy_next = r_dy + 9'sd1;
                        end
                    end else begin
                        w_dx_next = r_dx + 9'sd1;
                    end
                end
            end
            S_DONE: begin
                busy         = 1'b1;
                done         = 1'b1;
                w_state_next = S_IDLE;
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    assign mem_req   = w_req;
    assign mem_we    = w_req & mem_grant;
    assign mem_addr  = w_req ? w_addr : '0;
    assign mem_wdata = w_req ? r_type : 2'd0;

endmodule
`default_nettype wire
